// File: rtl/verificador_respuesta.sv
// verificador_respuesta: sweeps 2-input vectors, waits SETTLE cycles, checks outF against TRUTH; define CHECKER_CAPTURE_EN to capture observed F into obs_map
module verificador_respuesta #(
  parameter logic [3:0] TRUTH = 4'b0110,
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       vec_valid,
  input  logic       inA,
  input  logic       inB,
  input  logic       outF,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] seen_mask,
  output logic [3:0] obs_map
);
  typedef enum logic [2:0] {S_IDLE, S_ARM, S_SETTLE, S_SAMPLE, S_DONE} state_t;
  state_t state, nextState;
  logic [1:0] vecQ;
  logic [3:0] cnt, seenNext;
  logic [2:0] errNext;
  logic clearRun, latchVec;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else state <= nextState;
  always_comb begin
    nextState = state;
    seenNext = seen_mask | (4'b0001 << vecQ);
    errNext = (outF != TRUTH[vecQ]) && (err_count != 3'd4) ? err_count + 3'd1 : err_count;
    clearRun = (state == S_IDLE || state == S_DONE) && start;
    latchVec = (state == S_ARM && vec_valid && !seen_mask[{inA, inB}]) || (state == S_SETTLE && vec_valid);
    case (state)
      S_IDLE, S_DONE: nextState = start ? S_ARM : state;
      S_ARM:          nextState = latchVec ? S_SETTLE : S_ARM;
      S_SETTLE:       nextState = !vec_valid && cnt == 4'd0 ? S_SAMPLE : S_SETTLE;
      S_SAMPLE:       nextState = seenNext == 4'hF ? S_DONE : S_ARM;
      default:        nextState = S_IDLE;
    endcase
  end
  // status flags are registered from the next state so no input reaches an output combinationally
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      err_count <= '0;
      seen_mask <= '0;
      vecQ <= '0;
      cnt <= '0;
    end else begin
      busy <= nextState == S_ARM || nextState == S_SETTLE || nextState == S_SAMPLE;
      done <= nextState == S_DONE;
      if (clearRun) begin
        err_count <= '0;
        seen_mask <= '0;
        pass <= 1'b0;
      end
      if (latchVec) begin
        vecQ <= {inA, inB};
        cnt <= 4'(SETTLE - 1);
      end else if (state == S_SETTLE && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (state == S_SAMPLE) begin
        err_count <= errNext;
        seen_mask <= seenNext;
        if (seenNext == 4'hF) pass <= errNext == 3'd0;
      end
    end
`ifdef CHECKER_CAPTURE_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) obs_map <= '0;
    else if (clearRun) obs_map <= '0;
    else if (state == S_SAMPLE) obs_map[vecQ] <= outF;
`else
  assign obs_map = '0;
`endif
endmodule
